// File: rtl/mac_bank_seq.sv
// mac_bank_seq: sequencer for one 64-bin RAM-based multiply-accumulate bank.
// Clears the bank, runs one accumulate sweep per accepted sample until the
// programmed integration count is reached, then streams every bin out.
//
// Output stream handshake: out_valid is high whenever the skid FIFO holds an
// entry; a beat transfers on a cycle where out_valid and out_ready are both
// high; while out_valid is high and out_ready is low, out_data/out_addr/
// out_last hold steady; out_valid never drops without a transfer.
module mac_bank_seq #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int SWEEP_CYC = 66,
    parameter int READ_LAT  = 2,
    parameter int FIFO_D    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_int,
    input  logic              sample_valid,
    output logic              sample_ack,
    output logic              bank_clr,
    output logic              bank_sin,
    output logic              bank_read,
    output logic [ADDR_W-1:0] bank_raddr,
    input  logic [DATA_W-1:0] bank_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
    localparam int BINS   = 2**ADDR_W;
    localparam int WAIT_W = $clog2(SWEEP_CYC);
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int OCC_W  = $clog2(FIFO_D + READ_LAT + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ARM, S_SWEEP, S_RD_ENTER, S_READ, S_DRAIN
    } state_t;

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    nint_q;
    logic                overrun_q;
    logic                done_q;
    logic                bank_clr_q;
    logic                bank_sin_q;
    logic                bank_read_q;
    logic [ADDR_W-1:0]   bank_raddr_q;
    logic                issue_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [READ_LAT-1:0] pipe_vld_q;
    logic [ADDR_W-1:0]   pipe_addr_q [READ_LAT];
    logic [DATA_W-1:0]   fifo_data_q [FIFO_D];
    logic [ADDR_W-1:0]   fifo_addr_q [FIFO_D];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W:0]      count_q;

    logic                push_d;
    logic                pop_d;
    logic                issue_ok_d;
    logic                pending_d;
    logic [OCC_W-1:0]    inflight_d;
    logic [OCC_W-1:0]    occ_d;
    logic [ADDR_W-1:0]   head_addr_d;

    assign head_addr_d = fifo_addr_q[rd_ptr_q];
    assign out_valid   = (count_q != '0);
    assign out_data    = fifo_data_q[rd_ptr_q];
    assign out_addr    = head_addr_d;
    assign out_last    = out_valid && (head_addr_d == ADDR_W'(BINS - 1));
    assign sample_ack  = (state_q == S_ARM) && sample_valid;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign bank_clr    = bank_clr_q;
    assign bank_sin    = bank_sin_q;
    assign bank_read   = bank_read_q;
    assign bank_raddr  = bank_raddr_q;

    assign push_d = pipe_vld_q[READ_LAT-1];
    assign pop_d  = out_valid && out_ready;

    // Credit count: every issued-but-uncaptured read plus FIFO contents,
    // less a pop happening now, must leave room for one more read.
    always_comb begin
        inflight_d = OCC_W'(issue_q);
        pending_d  = issue_q;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_d = inflight_d + OCC_W'(pipe_vld_q[i]);
        end
        for (int i = 0; i < READ_LAT - 1; i++) begin
            pending_d = pending_d | pipe_vld_q[i];
        end
        occ_d      = inflight_d + OCC_W'(count_q) - OCC_W'(pop_d);
        issue_ok_d = (state_q == S_READ) && (occ_d < OCC_W'(FIFO_D));
    end

    // Main sequencer: run phases, bank command pulses and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            cnt_q        <= '0;
            nint_q       <= '0;
            overrun_q    <= 1'b0;
            done_q       <= 1'b0;
            bank_clr_q   <= 1'b0;
            bank_sin_q   <= 1'b0;
            bank_read_q  <= 1'b0;
            bank_raddr_q <= '0;
            issue_q      <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            bank_clr_q <= 1'b0;
            bank_sin_q <= 1'b0;
            done_q     <= 1'b0;
            issue_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nint_q     <= (n_int == '0) ? CNT_W'(1) : n_int;
                        overrun_q  <= 1'b0;
                        cnt_q      <= '0;
                        wait_q     <= '0;
                        rd_addr_q  <= '0;
                        bank_clr_q <= 1'b1;
                        state_q    <= S_CLEAR;
                    end
                end
                // ARM is entered so that the next pulse lands SWEEP_CYC
                // cycles after the clr pulse at the earliest.
                S_CLEAR: begin
                    if (wait_q == WAIT_W'(SWEEP_CYC - 2)) begin
                        wait_q  <= '0;
                        state_q <= S_ARM;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_ARM: begin
                    if (sample_valid) begin
                        bank_sin_q <= 1'b1;
                        cnt_q      <= cnt_q + CNT_W'(1);
                        wait_q     <= '0;
                        state_q    <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (sample_valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (wait_q == WAIT_W'(SWEEP_CYC - 2)) begin
                        wait_q  <= '0;
                        state_q <= (cnt_q < nint_q) ? S_ARM : S_RD_ENTER;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                // The read pulse reaches the pins one cycle before the
                // first address, i.e. SWEEP_CYC after the last sin.
                S_RD_ENTER: begin
                    bank_read_q <= 1'b1;
                    state_q     <= S_READ;
                end
                S_READ: begin
                    if (issue_ok_d) begin
                        bank_raddr_q <= rd_addr_q;
                        issue_q      <= 1'b1;
                        rd_addr_q    <= rd_addr_q + ADDR_W'(1);
                        if (rd_addr_q == ADDR_W'(BINS - 1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    bank_read_q <= pending_d;
                    if (pop_d && (head_addr_d == ADDR_W'(BINS - 1))) begin
                        done_q      <= 1'b1;
                        bank_read_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Read-latency pipeline: tracks which cycles carry a pending bin index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= issue_q;
            pipe_addr_q[0] <= bank_raddr_q;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    // Output skid FIFO: captures returning bank data with its bin index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            if (push_d) begin
                fifo_data_q[wr_ptr_q] <= bank_rdata;
                fifo_addr_q[wr_ptr_q] <= pipe_addr_q[READ_LAT-1];
                wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_d) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(push_d) - (PTR_W+1)'(pop_d);
        end
    end

endmodule

// File: tb/tb_mac_bank_seq.sv
// Testbench for mac_bank_seq: behavioural bank with 2-cycle read latency,
// per-run expected-bin queue, pin-level monitor and summary report.
`timescale 1ns/1ps
module tb_mac_bank_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] n_int;
    logic        sample_valid;
    logic        sample_ack;
    logic        bank_clr;
    logic        bank_sin;
    logic        bank_read;
    logic [5:0]  bank_raddr;
    logic [31:0] bank_rdata;
    logic [31:0] out_data;
    logic [5:0]  out_addr;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    mac_bank_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_int(n_int),
        .sample_valid(sample_valid), .sample_ack(sample_ack),
        .bank_clr(bank_clr), .bank_sin(bank_sin), .bank_read(bank_read),
        .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overrun(overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bank model ----------------
    logic [31:0] ram [64];
    logic [31:0] rd_stage;
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_stage   <= '0;
            bank_rdata <= '0;
        end else begin
            rd_stage   <= ram[bank_raddr];
            bank_rdata <= rd_stage;
        end
    end

    // ---------------- scoreboard state ----------------
    logic [37:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    int valid_mode = 0;   // 0 off, 1 held high, 2 raise until ack then rest 70 cycles
    int ready_mode = 0;   // 0 always, 1 pattern 1,0,0,1, 2 random
    int gap_ctr    = 0;
    bit ack_flag   = 0;
    int rdy_phase  = 0;

    initial begin
        sample_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (valid_mode)
                1: sample_valid = 1'b1;
                2: begin
                    if (ack_flag) begin
                        ack_flag     = 0;
                        sample_valid = 1'b0;
                        gap_ctr      = 70;
                    end else if (gap_ctr > 0) begin
                        gap_ctr--;
                        sample_valid = 1'b0;
                    end else begin
                        sample_valid = 1'b1;
                    end
                end
                default: sample_valid = 1'b0;
            endcase
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rdy_phase = (rdy_phase + 1) % 4;
            case (ready_mode)
                1: out_ready = (rdy_phase == 0) || (rdy_phase == 3);
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    int clr_cnt, sin_cnt, ack_cnt, read_cnt, done_cnt, xfer_cnt;
    int excl_err, gap_err, stall_err, bubble_cnt, done_err;
    int clr_cyc, last_sin_cyc, first_gap, last_xfer_cyc;
    bit stall_prev;
    logic [31:0] prev_data;
    logic [5:0]  prev_addr;

    task automatic clear_stats();
        clr_cnt = 0; sin_cnt = 0; ack_cnt = 0; read_cnt = 0; done_cnt = 0;
        xfer_cnt = 0; excl_err = 0; gap_err = 0; stall_err = 0;
        bubble_cnt = 0; done_err = 0; first_gap = 0; last_xfer_cyc = -10;
    endtask

    always @(negedge clk) begin
        logic [37:0] e;
        cyc++;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (bank_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (bank_sin) begin
                if (sin_cnt == 0) first_gap = cyc - clr_cyc;
                else if (cyc - last_sin_cyc != 66) gap_err++;
                sin_cnt++;
                last_sin_cyc = cyc;
            end
            if (bank_clr && bank_sin) excl_err++;
            if (bank_read && (bank_clr || bank_sin)) excl_err++;
            if (bank_read) read_cnt++;
            if (sample_ack) begin ack_cnt++; ack_flag = 1; end
            if (done) begin
                done_cnt++;
                if (cyc != last_xfer_cyc + 1) done_err++;
            end
            if (stall_prev && (!out_valid || out_data !== prev_data || out_addr !== prev_addr))
                stall_err++;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (xfer_cnt > 1 && cyc != last_xfer_cyc + 1) bubble_cnt++;
                last_xfer_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", 64'(out_addr), 64'(999));
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_addr", 64'(out_addr), 64'(e[37:32]));
                    check("xfer_data", 64'(out_data), 64'(e[31:0]));
                    check("xfer_last", 64'(out_last), 64'(e[37:32] == 6'd63));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
        end
    end

    // ---------------- run driver ----------------
    task automatic load_bank(input int base);
        for (int k = 0; k < 64; k++) begin
            ram[k] = 32'(k * 1000 + base);
            exp_q.push_back({6'(k), ram[k]});
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        n_int = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        n_int = 16'($urandom_range(0, 65535));
    endtask

    task automatic run(input int n, input int vmode, input int rmode, input int base, input bit extra);
        int t;
        int sweeps;
        bit got_done;
        sweeps = (n == 0) ? 1 : n;
        exp_q.delete();
        load_bank(base);
        clear_stats();
        ack_flag   = 0;
        gap_ctr    = 0;
        valid_mode = vmode;
        ready_mode = rmode;
        pulse_start(n);
        t = 0;
        got_done = 0;
        while (!got_done && t < 20000) begin
            @(negedge clk);
            t++;
            if (t == 20) begin
                check("busy_running", 64'(busy), 64'(1));
                check("ovr_clr_on_start", 64'(overrun), 64'(0));
            end
            if (extra && t == 300) begin start = 1'b1; n_int = 16'd9; end
            if (extra && t == 301) start = 1'b0;
            if (done) begin
                got_done = 1;
                check("busy_after_done", 64'(busy), 64'(0));
            end
        end
        check("run_done_seen", 64'(got_done), 64'(1));
        valid_mode = 0;
        repeat (3) @(negedge clk);
        check("exp_left", 64'(exp_q.size()), 64'(0));
        check("clr_pulses", 64'(clr_cnt), 64'(1));
        check("sin_pulses", 64'(sin_cnt), 64'(sweeps));
        check("ack_count", 64'(ack_cnt), 64'(sweeps));
        check("clr_to_sin", 64'(first_gap), 64'(66));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("done_timing", 64'(done_err), 64'(0));
        check("xfer_count", 64'(xfer_cnt), 64'(64));
        check("excl_err", 64'(excl_err), 64'(0));
        check("stall_stable", 64'(stall_err), 64'(0));
        check("read_window", 64'(read_cnt >= 65), 64'(1));
        check("overrun", 64'(overrun), 64'(vmode == 1));
        if (vmode == 1) check("sin_spacing", 64'(gap_err), 64'(0));
        if (rmode == 0) check("zero_bubble", 64'(bubble_cnt), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        rst_n = 1'b0;
        start = 1'b0;
        n_int = '0;
        for (int k = 0; k < 64; k++) ram[k] = '0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({sample_ack, bank_clr, bank_sin, bank_read, bank_raddr,
              out_data, out_addr, out_last, out_valid, busy, done, overrun}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        run(1, 2, 0, 0, 0);                              // basic, ram[k]=k*1000
        run(3, 1, 0, $urandom_range(1, 50000), 1);       // held valid, start while busy
        run(0, 2, 2, $urandom_range(1, 50000), 0);       // n_int=0, random ready
        run(2, 2, 1, $urandom_range(1, 50000), 0);       // 1,0,0,1 backpressure

        // Reset in the middle of a sweep.
        exp_q.delete();
        load_bank(5);
        clear_stats();
        valid_mode = 1;
        ready_mode = 0;
        pulse_start(3);
        t = 0;
        while (sin_cnt == 0 && t < 500) begin @(negedge clk); t++; end
        check("rst_test_sin_seen", 64'(sin_cnt), 64'(1));
        repeat (10) @(negedge clk);
        check("ovr_before_rst", 64'(overrun), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_rst_outputs", 64'({sample_ack, bank_clr, bank_sin, bank_read, bank_raddr,
              out_data, out_addr, out_last, out_valid, busy, done, overrun}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        valid_mode = 0;
        exp_q.delete();
        repeat (5) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt), 64'(0));

        run(1, 2, 1, $urandom_range(1, 50000), 0);       // fresh run after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_bank_seq.md
Name: mac_bank_seq

Overview:
Sequencer for one 64-bin RAM-based 8x8->32 multiply-accumulate bank. It clears the bank, issues one accumulate sweep per accepted input sample for a programmed integration count, then streams all 64 accumulated bins out through a valid/ready interface. It sits between the sample front-end and the result read-out path, and is the only driver of the bank's clr/sin/read/rAddr pins.

Parameters:
ADDR_W, 6, bank address width; BINS = 2**ADDR_W
DATA_W, 32, bank accumulator and read-data width
CNT_W, 16, integration-count width
SWEEP_CYC, 66, cycles from a clr/sin pulse until the bank may accept the next command (1 entry + 64 sweep + 1 margin)
READ_LAT, 2, cycles from bank_raddr presented until the matching bank_rdata is valid
FIFO_D, 4, output skid FIFO depth (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low; same net also resets the bank
start  in  1  one-cycle request to begin a run; ignored unless idle
n_int  in  CNT_W  samples to integrate; latched on accepted start; 0 treated as 1
sample_valid  in  1  new sample present on the bank's B input
sample_ack  out  1  sample accepted into a sweep
bank_clr  out  1  to bank clr
bank_sin  out  1  to bank sin
bank_read  out  1  to bank read
bank_raddr  out  ADDR_W  to bank rAddr
bank_rdata  in  DATA_W  from bank rData
out_data  out  DATA_W  bin value
out_addr  out  ADDR_W  bin index
out_last  out  1  marks bin BINS-1
out_valid  out  1  stream valid
out_ready  in  1  stream ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last bin is accepted
overrun  out  1  sticky: sample dropped while bank busy; cleared on accepted start

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs are 0, FIFO empty, counters 0. Reset mid-run aborts with no done pulse.
- All bank_* outputs are registered. bank_clr and bank_sin are never high in the same cycle. bank_read is never high together with bank_clr or bank_sin.
- IDLE: start=1 latches n_int, clears overrun, goes to CLEAR.
- CLEAR: bank_clr=1 for exactly 1 cycle, then wait SWEEP_CYC cycles, then go to ARM. Sample counter = 0.
- ARM: sample_valid=1 in cycle t: sample_ack=1 in t (combinational), bank_sin=1 in t+1 only, counter+1, go to SWEEP.
- SWEEP: wait SWEEP_CYC cycles from the bank_sin cycle. Any sample_valid here is dropped: no ack, overrun<=1. On expiry, go to ARM if counter < n_int, otherwise go to RD_ENTER.
- RD_ENTER: bank_read=1 for 1 cycle, which moves the bank into read mode; then go to READ.
- READ: bank_read stays 1. Present bank_raddr = 0..BINS-1, one new address per cycle, only when (in-flight + FIFO occupancy) < FIFO_D. In-flight means issued and not yet returned within READ_LAT. bank_rdata captured READ_LAT cycles after an address goes into the FIFO with its index. After address BINS-1 is issued, go to DRAIN.
- DRAIN: bank_read=1 until the last capture, then 0. Stay until the FIFO is empty and the final handshake completes.
- Output: out_valid = FIFO non-empty. A transfer occurs when out_valid & out_ready; the head pops. Data/addr hold stable while out_valid & !out_ready. out_last=1 when out_addr=BINS-1. The transfer of bin BINS-1 pulses done in the next cycle and returns to IDLE.
- The FIFO never overflows (credit rule). Full FIFO with out_ready=0 stalls address issue indefinitely.
- Counter wrap: sample counter is CNT_W wide. n_int = 2**CNT_W-1 completes without wrap.
- start while busy: ignored, no effect. sample_valid outside ARM/SWEEP: ignored, no ack, no overrun.
- Zero-bubble streaming: with out_ready=1 throughout, all 64 bins are delivered in consecutive cycles after the first.

Test Plan:
- Reset then start, n_int=1, sample_valid pulsed in ARM, out_ready=1 -> one bank_clr, 66 cycles later one bank_sin; bank_read window present; 64 consecutive transfers with out_addr 0..63, out_last only on 63, done 1 cycle after; busy drops.
- n_int=3, sample_valid held high continuously -> exactly 3 bank_sin pulses spaced 66 cycles apart; overrun=1; sample_ack count = 3.
- n_int=0 -> behaves as n_int=1 (one sweep).
- Read backpressure: out_ready toggles 1,0,0,1 repeating -> no lost or duplicated bins, data stable during stalls, FIFO never exceeds 4, out_addr strictly increasing 0..63.
- Bank model preloaded with ram[k]=k*1000 and a 2-cycle read latency -> out_data == out_addr*1000 for all 64 bins.
- rst_n asserted mid-SWEEP, then a new start -> all outputs 0 at reset; no done; new run starts with bank_clr, and overrun is cleared.
